output_writeback: RTL

Downstream stage of `accelerator`: consumes the per-column accumulator vector on `out_top` and turns it into packed int8 result words in output BRAM. Each accepted vector is requantised per lane (rounding arithmetic right shift, saturation to int8, optional ReLU). The packed word is written at a self-incrementing address. One job covers `num_vec` vectors and ends with a `done` pulse.

---
 rtl/output_writeback.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/output_writeback.sv
// Requantises accelerator accumulator vectors to packed int8 words and writes them to output BRAM.
// Optional ReLU stage is built only when OUTPUT_WB_RELU_EN is defined.
module output_writeback #(
   parameter int unsigned ARRAYWIDTH = 8,
   parameter int unsigned ACC_W      = 32,
   parameter int unsigned OUT_W      = 8,
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned SHIFT_W    = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ADDR_W-1:0]             base_addr,
   input  logic [ADDR_W-1:0]             num_vec,
   input  logic [SHIFT_W-1:0]            shift,
   input  logic                          relu_en,
   input  logic                          in_valid,
   input  logic [ACC_W*ARRAYWIDTH-1:0]   in_data,
   output logic                          in_ready,
   output logic                          wr_en,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [OUT_W*ARRAYWIDTH-1:0]   wr_data,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned EXT_W     = ACC_W + 1;
   localparam int          SAT_MAX_I = (1 << (OUT_W - 1)) - 1;
   localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(SAT_MAX_I);
   localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(-SAT_MAX_I - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e state_q, state_d;

   logic [ADDR_W-1:0]  num_q, num_d;
   logic [ADDR_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic               job_ld, accept;

   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic                    s1_valid_q;
   logic [ADDR_W-1:0]       s1_addr_q;
   logic signed [EXT_W-1:0] s1_data_q [ARRAYWIDTH];
   logic signed [EXT_W-1:0] s1_res    [ARRAYWIDTH];
   logic signed [EXT_W-1:0] rnd;

   logic                         wr_en_q;
   logic [ADDR_W-1:0]            wr_addr_q;
   logic [OUT_W*ARRAYWIDTH-1:0]  wr_data_q, s2_word;

`ifdef OUTPUT_WB_RELU_EN
   logic relu_q, relu_d;
`else
   logic unused_relu_en;
   assign unused_relu_en = relu_en;
`endif

   assign job_ld  = (state_q == ST_IDLE) && start;
   assign accept  = in_valid && in_ready_q;
   assign cnt_inc = cnt_q + ADDR_W'(1);

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (accept && (cnt_inc == num_q)) state_d = ST_DRAIN;
         ST_DRAIN: if (!s1_valid_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Job parameters latch on start; count and address advance per accept
   always_comb begin
      num_d   = num_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
`ifdef OUTPUT_WB_RELU_EN
      relu_d  = relu_q;
`endif
      if (job_ld) begin
         num_d   = num_vec;
         shift_d = shift;
         cnt_d   = '0;
         addr_d  = base_addr;
`ifdef OUTPUT_WB_RELU_EN
         relu_d  = relu_en;
`endif
      end else if (accept) begin
         cnt_d  = cnt_inc;
         addr_d = addr_q + ADDR_W'(1);
      end
   end

   // Output decode from next state so the control outputs are registered
   always_comb begin
      in_ready_d = (state_d == ST_RUN) && (cnt_d < num_d);
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         num_q      <= '0;
         shift_q    <= '0;
         cnt_q      <= '0;
         addr_q     <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef OUTPUT_WB_RELU_EN
         relu_q     <= 1'b0;
`endif
      end else begin
         num_q      <= num_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef OUTPUT_WB_RELU_EN
         relu_q     <= relu_d;
`endif
      end
   end

   // S1: rounding arithmetic right shift, one extra bit so the rounding add cannot wrap
   assign rnd = (shift_q == '0) ? '0 : (EXT_W'(1) << (shift_q - SHIFT_W'(1)));

   always_comb begin
      for (int unsigned i = 0; i < ARRAYWIDTH; i++) begin
         s1_res[i] = (EXT_W'($signed(in_data[ACC_W*i +: ACC_W])) + rnd) >>> shift_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         for (int unsigned i = 0; i < ARRAYWIDTH; i++) s1_data_q[i] <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_addr_q <= addr_q;
            for (int unsigned i = 0; i < ARRAYWIDTH; i++) s1_data_q[i] <= s1_res[i];
         end
      end
   end

   // S2: saturate to OUT_W, then optional ReLU
   always_comb begin
      s2_word = '0;
      for (int unsigned i = 0; i < ARRAYWIDTH; i++) begin
         if (s1_data_q[i] > SAT_HI)      s2_word[OUT_W*i +: OUT_W] = OUT_W'(SAT_HI);
         else if (s1_data_q[i] < SAT_LO) s2_word[OUT_W*i +: OUT_W] = OUT_W'(SAT_LO);
         else                            s2_word[OUT_W*i +: OUT_W] = s1_data_q[i][OUT_W-1:0];
`ifdef OUTPUT_WB_RELU_EN
         if (relu_q && s2_word[OUT_W*i + OUT_W - 1]) s2_word[OUT_W*i +: OUT_W] = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= s1_valid_q;
         if (s1_valid_q) begin
            wr_addr_q <= s1_addr_q;
            wr_data_q <= s2_word;
         end
      end
   end

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

endmodule
